// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer for the Sobel edge-detect datapath.
// Tracks the picture window inside the VGA raster and drives line-buffer bank
// selects, window indices, kernel-valid / output-valid strobes and the
// frame-synchronous gradient threshold.
// Optional feature macro: SOBEL_CTRL_STATS_EN (frame / abort counters).
module sobel_frame_ctrl #(
  parameter int          PIC_X_START    = 200,
  parameter int          PIC_Y_START    = 100,
  parameter int          PIC_WIDTH      = 200,
  parameter int          PIC_HEIGHT     = 200,
  parameter int          PIPE_LAT       = 2,
  parameter logic [20:0] THRESH_DEFAULT = 21'd15625
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        cfg_wr,
  input  logic [20:0] cfg_thresh,
  output logic        cfg_ack,
  output logic [20:0] sobel_thresh,
  output logic        win_active,
  output logic [7:0]  col_idx,
  output logic [7:0]  line_cnt,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic        kern_valid,
  output logic        out_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic [1:0]  ctrl_state,
  output logic [15:0] frame_cnt,
  output logic [7:0]  abort_cnt
);

  localparam logic [10:0] X0     = 11'(PIC_X_START);
  localparam logic [10:0] X_END  = 11'(PIC_X_START + PIC_WIDTH);
  localparam logic [10:0] X_LAST = 11'(PIC_X_START + PIC_WIDTH - 1);
  localparam logic [10:0] Y0     = 11'(PIC_Y_START);
  localparam logic [10:0] Y_END  = 11'(PIC_Y_START + PIC_HEIGHT);
  localparam logic [10:0] Y_FILL = 11'(PIC_Y_START + 1);
  localparam logic [10:0] Y_LAST = 11'(PIC_Y_START + PIC_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              x_in, y_in, in_win;
  logic              start, abort, fill_end, last_pix, in_frame;
  logic [10:0]       col_diff, row_diff;
  logic [7:0]        col_cur, row_cur;
  logic              win_nxt, kern_nxt;
  logic [PIPE_LAT:0] vld_pipe;   // [0] = kernel valid, [PIPE_LAT] = magnitude valid
  logic [20:0]       thresh_pend;

  // window decode on the raw scan coordinates (11-bit unsigned compares)
  assign x_in     = (pixel_x >= X0) && (pixel_x < X_END);
  assign y_in     = (pixel_y >= Y0) && (pixel_y < Y_END);
  assign in_win   = x_in && y_in;
  assign col_diff = pixel_x - X0;
  assign row_diff = pixel_y - Y0;
  assign col_cur  = col_diff[7:0];
  assign row_cur  = row_diff[7:0];

  assign in_frame = (state == FILL) || (state == RUN);
  assign start    = (state == IDLE) && enable && (pixel_x == X0) && (pixel_y == Y0);
  assign abort    = in_frame && (!enable || !y_in);
  assign fill_end = (pixel_x == X_LAST) && (pixel_y == Y_FILL);
  assign last_pix = (pixel_x == X_LAST) && (pixel_y == Y_LAST);

  // next-state and next-strobe decode; abort wins over any forward transition
  always_comb begin
    state_nxt = state;
    win_nxt   = 1'b0;
    kern_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
          win_nxt   = 1'b1;
        end
      end
      FILL: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          win_nxt = in_win;
          if (fill_end) state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          win_nxt  = in_win;
          kern_nxt = in_win && (col_cur >= 8'd2);
          if (last_pix) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // registered strobes, indices and the valid delay line (flushed on abort)
  always_ff @(posedge clk) begin
    if (rst) begin
      win_active  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      col_idx     <= 8'd0;
      line_cnt    <= 8'd0;
      vld_pipe    <= '0;
    end else begin
      win_active  <= win_nxt;
      frame_start <= start;
      frame_done  <= (state == DONE);
      if (in_win) begin
        col_idx  <= col_cur;
        line_cnt <= row_cur;
      end
      if (abort) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[PIPE_LAT-1:0], kern_nxt};
    end
  end

  // threshold: software writes land in the pending copy, frame start commits it
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_pend  <= THRESH_DEFAULT;
      sobel_thresh <= THRESH_DEFAULT;
      cfg_ack      <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr;
      if (cfg_wr) thresh_pend  <= cfg_thresh;
      if (start)  sobel_thresh <= thresh_pend;
    end
  end

  assign kern_valid = vld_pipe[0];
  assign out_valid  = vld_pipe[PIPE_LAT];
  assign wr_bank    = line_cnt[0];
  assign rd_bank    = ~line_cnt[0];
  assign ctrl_state = state;

`ifdef SOBEL_CTRL_STATS_EN
  // completed frames wrap, aborted frames saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      abort_cnt <= 8'd0;
    end else begin
      if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
      if (abort && (abort_cnt != 8'hFF)) abort_cnt <= abort_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = 16'd0;
  assign abort_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a shrunken raster (16x12 screen, 8x6 window)
// so many frames fit in a short run. A frame-level reference model predicts
// every output each cycle; literal checks pin counts and threshold timing.
module tb_sobel_frame_ctrl;
  localparam int X0 = 4, Y0 = 3, W = 8, H = 6, PL = 2;
  localparam int HT = 16, VT = 12;
  localparam int TDEF = 15625;
  localparam int FILL_END = (Y0 + 1) * 2048 + X0 + W - 1;
  localparam int LAST_KEY = (Y0 + H - 1) * 2048 + X0 + W - 1;

  logic        clk = 1'b0;
  logic        rst, enable, cfg_wr;
  logic [10:0] pixel_x, pixel_y;
  logic [20:0] cfg_thresh;
  logic        cfg_ack, win_active, wr_bank, rd_bank, kern_valid, out_valid;
  logic        frame_start, frame_done;
  logic [20:0] sobel_thresh;
  logic [7:0]  col_idx, line_cnt, abort_cnt;
  logic [1:0]  ctrl_state;
  logic [15:0] frame_cnt;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .PIC_X_START(X0), .PIC_Y_START(Y0), .PIC_WIDTH(W), .PIC_HEIGHT(H),
    .PIPE_LAT(PL), .THRESH_DEFAULT(21'd15625)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .cfg_wr(cfg_wr), .cfg_thresh(cfg_thresh), .cfg_ack(cfg_ack),
    .sobel_thresh(sobel_thresh), .win_active(win_active), .col_idx(col_idx),
    .line_cnt(line_cnt), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .kern_valid(kern_valid), .out_valid(out_valid), .frame_start(frame_start),
    .frame_done(frame_done), .ctrl_state(ctrl_state), .frame_cnt(frame_cnt),
    .abort_cnt(abort_cnt)
  );

  // ---------------- reference model ----------------
  bit          m_active, m_done, m_wa, m_kv, m_fs, m_fd, m_ack, m_ov;
  int          m_last_key, m_state, m_col, m_line, m_pend, m_thr, m_frames, m_aborts;
  logic [8:0]  kvh;

  // frame progress is judged by raster position relative to the fill-end and last pixel
  always @(posedge clk) begin
    int x, y, c, r, key;
    bit inw;
    x = int'(pixel_x); y = int'(pixel_y);
    c = x - X0; r = y - Y0; key = y * 2048 + x;
    inw = (c >= 0) && (c < W) && (r >= 0) && (r < H);
    if (rst) begin
      m_active = 0; m_done = 0; m_wa = 0; m_kv = 0; m_fs = 0; m_fd = 0; m_ack = 0;
      m_last_key = 0; m_state = 0; m_col = 0; m_line = 0;
      m_pend = TDEF; m_thr = TDEF; m_frames = 0; m_aborts = 0; kvh = '0; m_ov = 0;
    end else begin
      m_wa = 0; m_kv = 0; m_fs = 0; m_fd = 0;
      m_ack = cfg_wr;
      if (m_done) begin
        m_done = 0; m_fd = 1; m_frames = (m_frames + 1) % 65536;
      end else if (m_active) begin
        if (!enable || r < 0 || r >= H) begin
          m_active = 0;
          if (m_aborts < 255) m_aborts++;
          kvh = '0;
        end else begin
          m_wa = inw;
          m_kv = inw && (r >= 2) && (c >= 2);
          m_last_key = key;
          if (key == LAST_KEY) begin m_active = 0; m_done = 1; end
        end
      end else if (enable && x == X0 && y == Y0) begin
        m_active = 1; m_fs = 1; m_wa = 1; m_thr = m_pend; m_last_key = key;
      end
      if (inw) begin m_col = c; m_line = r; end
      if (cfg_wr) m_pend = int'(cfg_thresh);
      kvh = {kvh[7:0], m_kv};
      m_ov = kvh[PL];
      m_state = m_done ? 3 : (m_active ? ((m_last_key >= FILL_END) ? 2 : 1) : 0);
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    chk(n, a, e);
  endtask

  // per-cycle comparison against the model
  bit started = 0;
  always @(negedge clk) if (started) begin
    int efc, eac;
`ifdef SOBEL_CTRL_STATS_EN
    efc = m_frames; eac = m_aborts;
`else
    efc = 0; eac = 0;
`endif
    vectors++;
    chk("ctrl_state",   32'(ctrl_state),   32'(m_state));
    chk("win_active",   32'(win_active),   32'(m_wa));
    chk("col_idx",      32'(col_idx),      32'(m_col));
    chk("line_cnt",     32'(line_cnt),     32'(m_line));
    chk("wr_bank",      32'(wr_bank),      32'(m_line % 2));
    chk("rd_bank",      32'(rd_bank),      32'(1 - (m_line % 2)));
    chk("kern_valid",   32'(kern_valid),   32'(m_kv));
    chk("out_valid",    32'(out_valid),    32'(m_ov));
    chk("frame_start",  32'(frame_start),  32'(m_fs));
    chk("frame_done",   32'(frame_done),   32'(m_fd));
    chk("cfg_ack",      32'(cfg_ack),      32'(m_ack));
    chk("sobel_thresh", 32'(sobel_thresh), 32'(m_thr));
    chk("frame_cnt",    32'(frame_cnt),    32'(efc));
    chk("abort_cnt",    32'(abort_cnt),    32'(eac));
  end

  // per-frame tallies of DUT strobes for the literal checks
  int kv_cnt, ov_cnt, fs_cnt, fd_cnt, first_col, first_line, start_thr;
  bit seen_kv;
  always @(negedge clk) begin
    if (frame_start) begin fs_cnt++; start_thr = int'(sobel_thresh); end
    if (frame_done) fd_cnt++;
    if (out_valid) ov_cnt++;
    if (kern_valid) begin
      if (!seen_kv) begin first_col = int'(col_idx); first_line = int'(line_cnt); end
      seen_kv = 1; kv_cnt++;
    end
  end

  task automatic clr();
    kv_cnt = 0; ov_cnt = 0; fs_cnt = 0; fd_cnt = 0; seen_kv = 0;
    first_col = -1; first_line = -1;
  endtask

  // one raster with optional write / enable drop / reset at given raster indices
  task automatic scan_frame(input int wr_at, input int wv, input int dis_at, input int rst_at);
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        int idx;
        idx = y * HT + x;
        pixel_x = 11'(x); pixel_y = 11'(y);
        cfg_wr = (idx == wr_at); cfg_thresh = 21'(wv);
        if (idx == dis_at) enable = 1'b0;
        rst = (idx == rst_at);
        @(posedge clk); #1;
        if (idx == rst_at) begin
          lit("rst_thresh", 32'(sobel_thresh), TDEF);
          lit("rst_state", 32'(ctrl_state), 0);
          lit("rst_kern", 32'(kern_valid), 0);
          lit("rst_col", 32'(col_idx), 0);
          lit("rst_rd_bank", 32'(rd_bank), 1);
        end
      end
    cfg_wr = 1'b0; rst = 1'b0;
  endtask

  // raster with random enable flicker, config writes, off-window row jumps, rare resets
  task automatic scan_random();
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        pixel_x = 11'(x); pixel_y = 11'(y);
        if ($urandom_range(0, 199) == 0) begin
          pixel_x = 11'($urandom_range(0, HT - 1));
          pixel_y = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, Y0 - 1))
                                                : 11'($urandom_range(Y0 + H, VT - 1));
        end
        if (enable) enable = ($urandom_range(0, 249) != 0);
        else        enable = ($urandom_range(0, 29) == 0);
        cfg_wr = ($urandom_range(0, 29) == 0);
        cfg_thresh = 21'($urandom);
        rst = ($urandom_range(0, 1999) == 0);
        @(posedge clk); #1;
      end
    cfg_wr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int stats;
`ifdef SOBEL_CTRL_STATS_EN
    stats = 1;
`else
    stats = 0;
`endif
    rst = 1'b1; enable = 1'b0; cfg_wr = 1'b0; cfg_thresh = '0;
    pixel_x = '0; pixel_y = '0;
    clr(); start_thr = -1;
    started = 1;
    repeat (3) @(posedge clk);
    #1;
    lit("reset_thresh", 32'(sobel_thresh), TDEF);
    lit("reset_rd_bank", 32'(rd_bank), 1);
    lit("reset_state", 32'(ctrl_state), 0);
    lit("reset_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b0; enable = 1'b1;

    // clean frame: (W-2)*(H-2) = 24 kernels, first at window (2,2)
    clr(); scan_frame(-1, 0, -1, -1);
    lit("f1_kern_cnt", kv_cnt, 24);
    lit("f1_out_cnt", ov_cnt, 24);
    lit("f1_starts", fs_cnt, 1);
    lit("f1_dones", fd_cnt, 1);
    lit("f1_first_col", first_col, 2);
    lit("f1_first_line", first_line, 2);
    lit("f1_start_thr", start_thr, TDEF);

    // mid-frame write does not disturb the running frame
    clr(); scan_frame(5 * HT + 2, 20000, -1, -1);
    lit("f2_thresh_hold", 32'(sobel_thresh), TDEF);
    lit("f2_start_thr", start_thr, TDEF);

    // write on the start edge: this frame gets 20000, next frame 9000
    clr(); scan_frame(Y0 * HT + X0, 9000, -1, -1);
    lit("f3_start_thr", start_thr, 20000);
    lit("f3_frame_cnt", 32'(frame_cnt), stats * 3);
    clr(); scan_frame(-1, 0, -1, -1);
    lit("f4_start_thr", start_thr, 9000);

    // abort at window row 3, column 2
    clr(); scan_frame(-1, 0, (Y0 + 3) * HT + X0 + 2, -1);
    lit("abort_dones", fd_cnt, 0);
    lit("abort_kern_cnt", kv_cnt, 6);
    lit("abort_cnt", 32'(abort_cnt), stats);
    lit("abort_state", 32'(ctrl_state), 0);
    enable = 1'b1;
    clr(); scan_frame(-1, 0, -1, -1);
    lit("reen_kern_cnt", kv_cnt, 24);
    lit("reen_dones", fd_cnt, 1);

    // mid-frame reset at window row 4
    clr(); scan_frame(-1, 0, -1, (Y0 + 4) * HT + X0 + 1);
    lit("rst_dones", fd_cnt, 0);
    lit("rst_frame_cnt", 32'(frame_cnt), 0);

    for (int f = 0; f < 24; f++) scan_random();
    enable = 1'b1;
    scan_frame(-1, 0, -1, -1);
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Sequencer for the Sobel edge-detect datapath. Watches the VGA scan coordinates, tracks the 200×200 picture window, and drives the datapath's control: line-buffer ping-pong bank selects, column/row indices, kernel-valid and pipeline-aligned output-valid strobes. It also owns the gradient-magnitude threshold register, which software updates at any time and which takes effect only at a frame boundary. It sits between the pixel-timing generator and the gradient datapath and replaces its free-running `line_clk`/`state` logic.

## Interface
- `PIC_X_START`, 200: first window column in screen coordinates.
- `PIC_Y_START`, 100: first window row in screen coordinates.
- `PIC_WIDTH`, 200: window width in pixels, 3..255.
- `PIC_HEIGHT`, 200: window height in lines, 3..255.
- `PIPE_LAT`, 2: datapath latency from kernel-valid to magnitude-valid, 1..8.
- `THRESH_DEFAULT`, 15625: reset value of the squared-magnitude threshold.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: allows frames to start; deassertion aborts the frame in progress.
- `pixel_x` in 11: current scan column.
- `pixel_y` in 11: current scan row.
- `cfg_wr` in 1: one-cycle write strobe for the threshold.
- `cfg_thresh` in 21: new threshold value.
- `cfg_ack` out 1: one-cycle pulse, the cycle after `cfg_wr`.
- `sobel_thresh` out 21: threshold in force for the current frame.
- `win_active` out 1: current pixel is inside the window and the FSM is in FILL or RUN.
- `col_idx` out 8: `pixel_x - PIC_X_START`.
- `line_cnt` out 8: window row index.
- `wr_bank` out 1: line buffer to write (0 = line1, 1 = line2).
- `rd_bank` out 1: always `~wr_bank`.
- `kern_valid` out 1: full 3×3 neighbourhood available this cycle.
- `out_valid` out 1: `kern_valid` delayed by `PIPE_LAT`.
- `frame_start` out 1: one-cycle pulse.
- `frame_done` out 1: one-cycle pulse.
- `ctrl_state` out 2: FSM state (IDLE=0, FILL=1, RUN=2, DONE=3).
- `frame_cnt` out 16: completed-frame count (see Configuration).
- `abort_cnt` out 8: aborted-frame count (see Configuration).

## Operation
- `in_win` = `pixel_x` in [X0, X0+W) and `pixel_y` in [Y0, Y0+H), where X0 = `PIC_X_START`, Y0 = `PIC_Y_START`, W = `PIC_WIDTH`, H = `PIC_HEIGHT`. All comparisons are 11-bit unsigned.

FSM transitions:
- **IDLE → FILL** when `enable` and (`pixel_x`, `pixel_y`) = (X0, Y0).
  - Pulses `frame_start`.
  - Loads `sobel_thresh` from the pending register.
- **FILL → RUN** after pixel (X0+W−1, Y0+1), i.e. the first two lines have been buffered.
- **RUN → DONE** after pixel (X0+W−1, Y0+H−1).
- **DONE → IDLE** unconditionally; pulses `frame_done`.
- **Abort:** in FILL or RUN, if `enable` = 0 or `pixel_y` is outside [Y0, Y0+H), go to IDLE.
  - No `frame_done` pulse.
  - The `out_valid` delay line is flushed.
  - `win_active`, `kern_valid` and `out_valid` drop on the same edge.

Datapath control:
- `line_cnt` = `pixel_y - Y0`.
- `wr_bank` = `line_cnt[0]`, so row 0 writes line1.
- `col_idx` and `line_cnt` hold their last value outside the window.
- `kern_valid` = state RUN and `in_win` and `col_idx` ≥ 2.

Threshold configuration:
- `cfg_wr` writes `cfg_thresh` into the pending register; the last write before a frame start wins.
- If `cfg_wr` coincides with the IDLE→FILL edge, `sobel_thresh` takes the old pending value and the new value waits for the next frame.
- A write during FILL, RUN or DONE never changes `sobel_thresh` mid-frame.

Reset values:
- state IDLE, all strobes 0, `col_idx` = `line_cnt` = 0, `wr_bank` = 0, `rd_bank` = 1.
- `sobel_thresh` and the pending register = `THRESH_DEFAULT`.
- Counters = 0.

## Timing
- All outputs are registered and reflect the `pixel_x`/`pixel_y` sampled on the previous edge (1-cycle latency).
- `frame_start`, `win_active`, `col_idx` = 0 and `line_cnt` = 0 all rise on the edge that samples (X0, Y0).
- The first `kern_valid` is for sample (X0+2, Y0+2); `out_valid` follows it by exactly `PIPE_LAT` cycles.
- `kern_valid` pulses per frame: (W−2)·(H−2) = 39204 at the defaults.
- `frame_done` is asserted one cycle after the last-pixel sample, then the FSM returns to IDLE.
- `rst` has priority over every event, including a mid-frame reset.

## Configuration
- Macro `SOBEL_CTRL_STATS_EN`.
- **Defined:**
  - `frame_cnt` increments on each `frame_done` and wraps at 65535 → 0.
  - `abort_cnt` increments on each abort and saturates at 255.
- **Undefined:** both ports are tied to 0 and no counter logic is generated.

## Test plan
- **Full frame:** reset, `enable` = 1, scan 800×525 raster → one `frame_start`, 39204 `kern_valid` pulses, first at (202, 102) in window coordinates (2, 2), and `out_valid` count = 39204 with a 2-cycle offset.
- **Bank alternation:** `line_cnt` 0/1/2/3 → `wr_bank` 0/1/0/1, with `rd_bank` always the inverse.
- **Threshold timing:** write 20000 mid-frame → `cfg_ack` next cycle, `sobel_thresh` stays 15625 until the next `frame_start`, then becomes 20000. Write 9000 on the `frame_start` edge → value applies one frame later.
- **Abort:** drop `enable` at window row 50 → state IDLE next edge, strobes 0, no `frame_done`, `abort_cnt` = 1 with STATS. Re-enable → a clean frame at the next (200, 100).
- **Mid-frame reset:** assert `rst` at row 120 → all outputs at reset values next edge, threshold back to 15625.
- **Stats:** 3 full frames → `frame_cnt` = 3. Without `SOBEL_CTRL_STATS_EN` → `frame_cnt` stays 0.
